// File: rtl/axi_mem_responder_if.sv
// axi_mem_responder_if: AXI4 bus bundle between a master and the memory responder
interface axi_mem_responder_if #(
    parameter int ID_W   = 6,
    parameter int USER_W = 32,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 512
);
    logic [ID_W-1:0]     awid;
    logic [USER_W-1:0]   awuser;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [USER_W-1:0]   buser;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [USER_W-1:0]   aruser;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [USER_W-1:0]   ruser;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    modport slave (
        input  awid, awuser, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, buser, bresp, bvalid,
        input  bready,
        input  arid, aruser, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, ruser, rdata, rresp, rlast, rvalid,
        input  rready
    );
    modport master (
        output awid, awuser, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, buser, bresp, bvalid,
        output bready,
        output arid, aruser, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, ruser, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave memory with programmable read/B latency, INCR/FIXED bursts and SLVERR on illegal bursts
module axi_mem_responder #(
    parameter int DATA_W     = 512,
    parameter int ADDR_W     = 32,
    parameter int ID_W       = 6,
    parameter int USER_W     = 32,
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 4,
    parameter int B_LATENCY  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    axi_mem_responder_if.slave  s,
    output logic [15:0]         err_count
);
    localparam int LB  = $clog2(DATA_W / 8);
    localparam int IW  = $clog2(DEPTH);
    localparam int RLW = $clog2(RD_LATENCY + 1);
    localparam int BLW = $clog2(B_LATENCY + 1);
    typedef enum logic [2:0] {W_OFF, W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_OFF, R_IDLE, R_WAIT, R_DATA} r_state_t;
    w_state_t          w_state, w_next;
    r_state_t          r_state, r_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [IW-1:0]     w_idx, r_idx;
    logic              w_fixed, w_legal, r_fixed, r_legal;
    logic [7:0]        w_len, r_len, r_cnt;
    logic [8:0]        w_cnt;
    logic [BLW-1:0]    w_lat;
    logic [RLW-1:0]    r_lat;
    logic [ID_W-1:0]   b_id;
    logic [USER_W-1:0] b_user;
    logic [1:0]        b_resp;
    logic [16:0]       err_sum;
    logic [ADDR_W-1:0] unused_addr;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_we, w_done, r_done, r_load;
    assign unused_addr = s.awaddr ^ s.araddr;
    assign aw_hs  = s.awvalid && s.awready;
    assign w_hs   = s.wvalid && s.wready;
    assign b_hs   = s.bvalid && s.bready;
    assign ar_hs  = s.arvalid && s.arready;
    assign r_hs   = s.rvalid && s.rready;
    assign w_we   = w_hs && w_legal && w_cnt <= {1'b0, w_len};
    assign w_done = w_lat == BLW'(B_LATENCY - 1);
    assign r_done = r_lat == RLW'(RD_LATENCY - 1);
    assign r_load = (r_state == R_WAIT && r_done) || (r_state == R_DATA && r_hs && !s.rlast);
    assign s.awready = w_state == W_IDLE;
    assign s.wready  = w_state == W_DATA;
    assign s.bvalid  = w_state == W_RESP;
    assign s.bid     = b_id;
    assign s.buser   = b_user;
    assign s.bresp   = b_resp;
    assign s.arready = r_state == R_IDLE;
    assign s.rvalid  = r_state == R_DATA;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_OFF;
            r_state <= R_OFF;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end
    always_comb begin
        w_next = w_state;
        r_next = r_state;
        case (w_state)
            W_OFF:  w_next = W_IDLE;
            W_IDLE: w_next = s.awvalid ? W_DATA : W_IDLE;
            W_DATA: w_next = (s.wvalid && s.wlast) ? W_WAIT : W_DATA;
            W_WAIT: w_next = w_done ? W_RESP : W_WAIT;
            W_RESP: w_next = s.bready ? W_IDLE : W_RESP;
            default: w_next = W_OFF;
        endcase
        case (r_state)
            R_OFF:  r_next = R_IDLE;
            R_IDLE: r_next = s.arvalid ? R_WAIT : R_IDLE;
            R_WAIT: r_next = r_done ? R_DATA : R_WAIT;
            R_DATA: r_next = (s.rready && s.rlast) ? R_IDLE : R_DATA;
            default: r_next = R_OFF;
        endcase
    end
    // Strobed writes; the read register below samples the pre-edge word on a same-edge collision
    always_ff @(posedge clk) begin
        if (w_we)
            for (int b = 0; b < DATA_W / 8; b++)
                if (s.wstrb[b]) mem[w_idx][b*8 +: 8] <= s.wdata[b*8 +: 8];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_idx <= '0;
            w_fixed <= 1'b0;
            w_legal <= 1'b0;
            w_len <= '0;
            w_cnt <= '0;
            w_lat <= '0;
            b_id <= '0;
            b_user <= '0;
            b_resp <= '0;
        end else begin
            if (aw_hs) begin
                b_id <= s.awid;
                b_user <= s.awuser;
                w_idx <= s.awaddr[LB +: IW];
                w_fixed <= s.awburst == 2'd0;
                w_legal <= s.awburst < 2'd2 && s.awsize == 3'(LB);
                w_len <= s.awlen;
                w_cnt <= '0;
            end
            if (w_hs) begin
                w_cnt <= w_cnt + 9'd1;
                w_idx <= w_fixed ? w_idx : w_idx + IW'(1);
                if (s.wlast) b_resp <= (w_legal && w_cnt == {1'b0, w_len}) ? 2'b00 : 2'b10;
            end
            w_lat <= w_state == W_WAIT ? w_lat + BLW'(1) : '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_fixed <= 1'b0;
            r_legal <= 1'b0;
            r_len <= '0;
            r_cnt <= '0;
            r_lat <= '0;
            s.rid <= '0;
            s.ruser <= '0;
            s.rdata <= '0;
            s.rresp <= '0;
            s.rlast <= 1'b0;
        end else begin
            if (ar_hs) begin
                s.rid <= s.arid;
                s.ruser <= s.aruser;
                r_idx <= s.araddr[LB +: IW];
                r_fixed <= s.arburst == 2'd0;
                r_legal <= s.arburst < 2'd2 && s.arsize == 3'(LB);
                r_len <= s.arlen;
                r_cnt <= '0;
            end
            if (r_load) begin
                s.rdata <= r_legal ? mem[r_idx] : '0;
                s.rresp <= r_legal ? 2'b00 : 2'b10;
                s.rlast <= r_cnt == r_len;
                r_cnt <= r_cnt + 8'd1;
                r_idx <= r_fixed ? r_idx : r_idx + IW'(1);
            end else if (r_hs && s.rlast) begin
                s.rlast <= 1'b0;
            end
            r_lat <= r_state == R_WAIT ? r_lat + RLW'(1) : '0;
        end
    end
    // One count per SLVERR burst: B handshake for writes, rlast handshake for reads
    assign err_sum = {1'b0, err_count} + 17'(b_hs && s.bresp[1]) + 17'(r_hs && s.rlast && s.rresp[1]);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_count <= '0;
        else err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: random and directed AXI traffic checked every cycle against a transaction-level memory model
module tb_axi_mem_responder;
    localparam int DW = 32, AW = 32, IDW = 6, UW = 8, DEPTH = 16, RD = 4, BL = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] err_count;
    always #5 clk = ~clk;
    axi_mem_responder_if #(.ID_W(IDW), .USER_W(UW), .ADDR_W(AW), .DATA_W(DW)) bus ();
    axi_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IDW), .USER_W(UW), .DEPTH(DEPTH),
                        .RD_LATENCY(RD), .B_LATENCY(BL))
        dut (.clk(clk), .rst_n(rst_n), .s(bus), .err_count(err_count));
    int vec = 0, mis = 0, cyc = 0;
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        vec++;
        if (a !== e) begin
            mis++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask
    // Transaction-level model: memory array, one pending write and one pending read burst
    typedef struct {logic [31:0] d; logic [1:0] resp; bit last;} beat_t;
    logic [31:0] mm [DEPTH];
    beat_t rq[$];
    bit m_live, m_fix, m_leg, eb, er;
    int m_wph, m_rph, w_idx, w_cnt, w_len, b_due, r_due;
    logic [5:0] m_bid, m_rid;
    logic [7:0] m_buser, m_ruser;
    logic [1:0] m_bresp;
    logic [15:0] m_err;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_live = 0; m_wph = 0; m_rph = 0; m_err = 0;
            rq.delete();
        end else begin
            if (m_wph == 0) begin
                if (m_live && bus.awvalid) begin
                    m_bid = bus.awid; m_buser = bus.awuser;
                    w_idx = int'((bus.awaddr >> 2) % DEPTH);
                    m_fix = bus.awburst == 0;
                    m_leg = bus.awburst < 2 && bus.awsize == 2;
                    w_len = int'(bus.awlen); w_cnt = 0; m_wph = 1;
                end
            end else if (m_wph == 1) begin
                if (bus.wvalid) begin
                    if (m_leg && w_cnt <= w_len)
                        for (int b = 0; b < 4; b++)
                            if (bus.wstrb[b]) mm[w_idx][b*8 +: 8] = bus.wdata[b*8 +: 8];
                    if (!m_fix) w_idx = (w_idx + 1) % DEPTH;
                    if (bus.wlast) begin
                        m_bresp = (m_leg && w_cnt == w_len) ? 2'b00 : 2'b10;
                        b_due = cyc + 1 + BL; m_wph = 2;
                    end
                    w_cnt++;
                end
            end else if (cyc >= b_due && bus.bready) begin
                if (m_bresp == 2'b10 && m_err != 16'hFFFF) m_err++;
                m_wph = 0;
            end
            if (m_rph == 0) begin
                if (m_live && bus.arvalid) begin
                    int idx;
                    bit leg;
                    leg = bus.arburst < 2 && bus.arsize == 2;
                    idx = int'((bus.araddr >> 2) % DEPTH);
                    for (int i = 0; i <= int'(bus.arlen); i++) begin
                        rq.push_back('{leg ? mm[idx] : 32'h0, leg ? 2'b00 : 2'b10, i == int'(bus.arlen)});
                        if (bus.arburst != 0) idx = (idx + 1) % DEPTH;
                    end
                    m_rid = bus.arid; m_ruser = bus.aruser;
                    r_due = cyc + 1 + RD; m_rph = 1;
                end
            end else if (cyc >= r_due && bus.rready) begin
                beat_t bt;
                bt = rq.pop_front();
                if (bt.last) begin
                    if (bt.resp == 2'b10 && m_err != 16'hFFFF) m_err++;
                    m_rph = 0;
                end
            end
            m_live = 1;
            cyc++;
        end
    end
    always @(negedge clk) begin
        if (!rst_n || !m_live) begin
            chk("idle_ctl", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.rlast, err_count}, 0);
            chk("idle_ids", {bus.bid, bus.buser, bus.bresp, bus.rid, bus.ruser, bus.rresp}, 0);
            chk("idle_rdata", bus.rdata, 0);
        end else begin
            eb = m_wph == 2 && cyc >= b_due;
            er = m_rph == 1 && cyc >= r_due;
            chk("awready", bus.awready, m_wph == 0);
            chk("wready", bus.wready, m_wph == 1);
            chk("arready", bus.arready, m_rph == 0);
            chk("bvalid", bus.bvalid, eb);
            chk("rvalid", bus.rvalid, er);
            chk("err_count", err_count, m_err);
            if (eb) chk("b_fields", {bus.bid, bus.buser, bus.bresp}, {m_bid, m_buser, m_bresp});
            if (er && rq.size() > 0)
                chk("r_fields", {bus.rid, bus.ruser, bus.rdata, bus.rresp, bus.rlast},
                    {m_rid, m_ruser, rq[0].d, rq[0].resp, rq[0].last});
        end
    end
    int t_hs, t_b, t_ar, t_r0, t_rl, rlast_n;
    logic [5:0] g_bid;
    logic [1:0] g_bresp;
    logic [31:0] rd_log[$];
    task automatic hs(input int sel, output int c);
        bit ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            ok = sel == 0 ? bus.awready : sel == 1 ? bus.wready : bus.arready;
            @(negedge clk);
        end
        chk("hs_timeout", ok, 1);
        c = cyc;
    endtask
    task automatic wr(input logic [5:0] id, input logic [31:0] addr, input int len, input int nb,
                      input logic [2:0] size, input logic [1:0] burst, input logic [31:0] d0,
                      input logic [3:0] s0, input bit rnd);
        int c;
        bit ok = 0;
        bus.awid = id; bus.awuser = 8'($urandom); bus.awaddr = addr; bus.awlen = 8'(len);
        bus.awsize = size; bus.awburst = burst; bus.awvalid = 1;
        hs(0, c);
        bus.awvalid = 0;
        for (int i = 0; i < nb; i++) begin
            bus.wdata = rnd ? $urandom : d0 + 32'(i);
            bus.wstrb = rnd ? 4'($urandom) : s0;
            bus.wlast = i == nb - 1;
            bus.wvalid = 1;
            hs(1, t_hs);
        end
        bus.wvalid = 0; bus.wlast = 0; t_b = -1;
        for (int k = 0; k < 200 && !ok; k++) begin
            bus.bready = rnd ? 1'($urandom) : 1'b1;
            if (bus.bvalid && t_b < 0) t_b = cyc;
            if (bus.bvalid && bus.bready) begin
                ok = 1; g_bid = bus.bid; g_bresp = bus.bresp;
            end
            @(negedge clk);
        end
        bus.bready = 0;
        chk("b_timeout", ok, 1);
    endtask
    task automatic rd(input logic [5:0] id, input logic [31:0] addr, input int len,
                      input logic [2:0] size, input logic [1:0] burst, input bit rnd);
        bit ok = 0;
        bus.arid = id; bus.aruser = 8'($urandom); bus.araddr = addr; bus.arlen = 8'(len);
        bus.arsize = size; bus.arburst = burst; bus.arvalid = 1;
        hs(2, t_ar);
        bus.arvalid = 0;
        rd_log.delete(); t_r0 = -1; rlast_n = 0;
        for (int k = 0; k < 400 && !ok; k++) begin
            bus.rready = rnd ? 1'($urandom) : 1'b1;
            if (bus.rvalid && t_r0 < 0) t_r0 = cyc;
            if (bus.rvalid && bus.rready) begin
                rd_log.push_back(bus.rdata);
                rlast_n += int'(bus.rlast);
                if (bus.rlast) begin
                    ok = 1; t_rl = cyc;
                end
            end
            @(negedge clk);
        end
        bus.rready = 0;
        chk("r_timeout", ok, 1);
    endtask
    initial begin
        int ln, nb, r;
        logic [2:0] sz;
        logic [1:0] bt;
        {bus.awid, bus.awuser, bus.awaddr, bus.awlen, bus.awsize, bus.awburst, bus.awvalid} = '0;
        {bus.wdata, bus.wstrb, bus.wlast, bus.wvalid, bus.bready} = '0;
        {bus.arid, bus.aruser, bus.araddr, bus.arlen, bus.arsize, bus.arburst, bus.arvalid, bus.rready} = '0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        wr(6'b100000, 32'h40, 0, 1, 3'd2, 2'd1, 32'hA5A5A5A5, 4'hF, 0);
        chk("b_latency", 64'(t_b - t_hs), BL);
        chk("bresp_ok", g_bresp, 2'b00);
        chk("bid_echo", g_bid, 6'b100000);
        wr(6'd1, 32'h0, 15, 16, 3'd2, 2'd1, $urandom, 4'hF, 0);
        wr(6'd2, 32'h0, 3, 4, 3'd2, 2'd1, 32'h10000000, 4'hF, 0);
        rd(6'd3, 32'h0, 3, 3'd2, 2'd1, 0);
        chk("r_latency", 64'(t_r0 - t_ar), RD);
        chk("r_beats", rd_log.size(), 4);
        chk("r_nobubble", 64'(t_rl - t_r0), 3);
        chk("rlast_once", rlast_n, 1);
        if (rd_log.size() == 4)
            for (int i = 0; i < 4; i++) chk("r_data", rd_log[i], 32'h10000000 + 32'(i));
        wr(6'd4, 32'h20, 0, 1, 3'd2, 2'd1, 32'hFFFFFFFF, 4'hF, 0);
        wr(6'd4, 32'h20, 0, 1, 3'd2, 2'd1, 32'h12345678, 4'h3, 0);
        rd(6'd5, 32'h20, 0, 3'd2, 2'd1, 0);
        chk("strobe_merge", rd_log[0], 32'hFFFF5678);
        wr(6'd6, 32'h80, 1, 2, 3'd2, 2'd2, 32'h0BAD0000, 4'hF, 0);
        chk("wrap_bresp", g_bresp, 2'b10);
        chk("err_after_w", err_count, 1);
        rd(6'd7, 32'h80, 0, 3'd2, 2'd1, 0);
        chk("wrap_discarded", rd_log[0], 32'h10000000);
        rd(6'd7, 32'h0, 1, 3'd3, 2'd1, 0);
        chk("err_after_r", err_count, 2);
        chk("bad_rdata", rd_log[0], 0);
        rd(6'd8, 32'h10, 7, 3'd2, 2'd1, 1);
        chk("r8_beats", rd_log.size(), 8);
        chk("r8_last", rlast_n, 1);
        wr(6'd9, 32'h30, 1, 3, 3'd2, 2'd1, 0, 0, 1);
        chk("over_bresp", g_bresp, 2'b10);
        wr(6'd9, 32'h30, 3, 2, 3'd2, 2'd1, 0, 0, 1);
        chk("short_bresp", g_bresp, 2'b10);
        wr(6'd10, 32'h3C, 1, 2, 3'd2, 2'd1, 32'hCAFE0000, 4'hF, 0);
        rd(6'd11, 32'h0, 0, 3'd2, 2'd1, 0);
        chk("wrap_word0", rd_log[0], 32'hCAFE0001);
        for (int n = 0; n < 60; n++) begin
            ln = $urandom_range(0, 7);
            sz = ($urandom % 8 == 0) ? 3'd3 : 3'd2;
            bt = ($urandom % 8 == 0) ? 2'd2 + 2'($urandom % 2) : 2'($urandom % 2);
            if ($urandom % 2 == 0) begin
                nb = ln + 1;
                r = $urandom % 8;
                if (r == 0) nb = ln + 2;
                else if (r == 1 && ln > 0) nb = ln;
                wr(6'($urandom), $urandom, ln, nb, sz, bt, 0, 0, 1);
            end else begin
                rd(6'($urandom), $urandom, ln, sz, bt, 1);
            end
        end
        bus.arid = 6'd12; bus.araddr = 32'h0; bus.arlen = 8'd7; bus.arsize = 3'd2; bus.arburst = 2'd1;
        bus.arvalid = 1;
        hs(2, t_ar);
        bus.arvalid = 0; bus.rready = 0;
        repeat (RD + 2) @(negedge clk);
        chk("stall_rvalid", bus.rvalid, 1);
        #2 rst_n = 0;
        #1 chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_err", err_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        #1 chk("post_rst_arready0", bus.arready, 0);
        @(negedge clk);
        chk("post_rst_arready1", bus.arready, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
